// File: rtl/boruhatti_denetleyici.sv
// boruhatti_denetleyici: gathers eight serial operands, presents them to an
// external fixed-latency datapath, waits for its result and hands the
// captured result downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   veri            - serial operand stream (N bits)
//   veri_gecerli    - veri valid
//   veri_hazir      - block accepts an operand this cycle (registered)
//   sayilar         - eight operand slots to the datapath, slot k at [(k+1)N-1:kN]
//   giris_etkin     - datapath enable (registered)
//   sonuc           - datapath result (N+2 bits)
//   cikis           - captured result (N+2 bits)
//   cikis_gecerli   - cikis valid (registered)
//   cikis_hazir     - downstream accepts cikis
//   islem_sayisi    - completed operation count
//
// Optional feature: define ISLEM_SAYACI_EN to build the 16-bit operation
// counter; otherwise islem_sayisi is tied to zero and no flops are built.

module boruhatti_denetleyici #(
  parameter int unsigned N       = 8,
  parameter int unsigned GECIKME = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     veri,
  input  logic             veri_gecerli,
  output logic             veri_hazir,
  output logic [8*N-1:0]   sayilar,
  output logic             giris_etkin,
  input  logic [N+1:0]     sonuc,
  output logic [N+1:0]     cikis,
  output logic             cikis_gecerli,
  input  logic             cikis_hazir,
  output logic [15:0]      islem_sayisi
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {TOPLA, GONDER, BEKLE, SUN} durum_t;

  durum_t          durum;
  durum_t          durum_next;
  logic [2:0]      idx;
  logic [CW-1:0]   sayac;
  logic            kabul;

  // An operand is taken only while collecting and both sides agree.
  assign kabul = veri_gecerli && veri_hazir && (durum == TOPLA);

  // Next-state decode; the registered outputs are derived from it.
  always_comb begin
    durum_next = durum;
    case (durum)
      TOPLA:  if (kabul && (idx == 3'd7)) durum_next = GONDER;
      GONDER: durum_next = BEKLE;
      BEKLE:  if (sayac <= CW'(1)) durum_next = SUN;
      SUN:    if (cikis_hazir) durum_next = TOPLA;
      default: durum_next = TOPLA;
    endcase
  end

  // State, operand slots, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum         <= TOPLA;
      idx           <= 3'd0;
      sayac         <= '0;
      sayilar       <= '0;
      cikis         <= '0;
      giris_etkin   <= 1'b0;
      veri_hazir    <= 1'b0;
      cikis_gecerli <= 1'b0;
    end else begin
      durum         <= durum_next;
      veri_hazir    <= (durum_next == TOPLA);
      cikis_gecerli <= (durum_next == SUN);
      giris_etkin   <= (durum_next == GONDER) || (durum_next == BEKLE);

      if (kabul) begin
        sayilar[32'(idx)*N +: N] <= veri;
        idx                      <= idx + 3'd1;   // wraps to 0 after the 8th beat
      end

      if (durum == GONDER) begin
        sayac <= CW'(GECIKME);
      end else if (durum == BEKLE) begin
        sayac <= sayac - CW'(1);
      end

      // Capture exactly on the BEKLE->SUN transition so cikis stays put in SUN.
      if ((durum == BEKLE) && (durum_next == SUN)) begin
        cikis <= sonuc;
      end
    end
  end

`ifdef ISLEM_SAYACI_EN
  // Counts SUN handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      islem_sayisi <= 16'd0;
    end else if ((durum == SUN) && cikis_hazir) begin
      islem_sayisi <= islem_sayisi + 16'd1;
    end
  end
`else
  assign islem_sayisi = 16'd0;
`endif

endmodule
